// File: rtl/riscv_stream_out_buf.sv
// riscv_stream_out_buf: FWFT FIFO with a one-word skid register between the
// PicoRV32 stream bridge and the next valid/ready stage.
module riscv_stream_out_buf #(
   parameter int DEPTH    = 16,
   parameter int AWIDTH   = 4,
   parameter     RAM_TYPE = "distributed"
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              val_in,
   input  logic [31:0]       din,
   output logic              ready_downward,
   output logic              val_o,
   output logic [31:0]       dout_o,
   input  logic              ready_i,
   output logic [AWIDTH:0]   count,
   output logic              overflow
);
   localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] ONE      = (AWIDTH+1)'(1);

   (* ram_style = RAM_TYPE *) logic [31:0] mem [DEPTH];

   logic [AWIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            skid_valid_q, skid_valid_d, overflow_q, overflow_d;
   logic [31:0]     skid_data_q, skid_data_d, src_data;
   logic            full, empty, pop, push;

   assign count          = wr_ptr_q - rd_ptr_q;
   assign full           = count == FULL_CNT;
   assign empty          = wr_ptr_q == rd_ptr_q;
   assign val_o          = !empty;
   assign dout_o         = mem[rd_ptr_q[AWIDTH-1:0]];
   assign ready_downward = !full && !skid_valid_q;
   assign overflow       = overflow_q;
   assign pop            = val_o && ready_i;
   // The skid word always goes first so ordering follows val_in order.
   assign src_data       = skid_valid_q ? skid_data_q : din;
   assign push           = (skid_valid_q || val_in) && (!full || pop);

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + ONE : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + ONE : rd_ptr_q;
      skid_valid_d = skid_valid_q ? !push : (val_in && !push);
      skid_data_d  = (!skid_valid_q && val_in && !push) ? din : skid_data_q;
      overflow_d   = overflow_q || (val_in && skid_valid_q);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         skid_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         skid_valid_q <= skid_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
      if (push && resetn)
         mem[wr_ptr_q[AWIDTH-1:0]] <= src_data;
   end
endmodule
